// File: rtl/rv_defs.sv
// Shared RV32-subset definitions: supported opcodes, NOP encoding and fetch FSM states.
package rv_defs;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        TRAP  = 2'd3
    } ifu_state_t;

    function automatic logic is_supported_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_LUI) ||
               (op == OP_IMM) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches over req/ack and hands the IR to decode.
// Define IFU_ILLEGAL_TRAP_EN to trap (sticky, reset-only exit) on unsupported opcodes.
module instr_fetch_unit
    import rv_defs::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic            illegal
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    ifu_state_t      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_dec_pc;
    logic [XLEN-1:0] r_redir_tgt;
    logic            r_redir_pend;
    logic [31:0]     r_ir;
    logic            r_imem_req;
    logic            r_dec_valid;

    logic [XLEN-1:0] w_redir_tgt;
    logic [XLEN-1:0] w_pc_next;
    logic            w_trap;

    assign w_redir_tgt = redir_pc & ALIGN_MASK;
    assign w_pc_next   = r_pc + XLEN'(PC_STEP);

`ifdef IFU_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign w_trap  = !is_supported_op(imem_rdata[6:0]);
    assign illegal = r_illegal;
`else
    assign w_trap  = 1'b0;
    assign illegal = 1'b0;
`endif

    // A request with imem_req low in FETCH is the one-cycle gap after a discarded response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_dec_pc     <= RESET_PC;
            r_redir_tgt  <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_ir         <= NOP_INSTR;
            r_imem_req   <= 1'b0;
            r_dec_valid  <= 1'b0;
`ifdef IFU_ILLEGAL_TRAP_EN
            r_illegal    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (redir_valid) begin
                        r_pc <= w_redir_tgt;
                    end
                    if (run) begin
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                        if (redir_valid) begin
                            r_pc <= w_redir_tgt;
                        end
                    end else if (imem_ack) begin
                        r_imem_req <= 1'b0;
                        if (r_redir_pend || redir_valid) begin
                            r_pc         <= redir_valid ? w_redir_tgt : r_redir_tgt;
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_ir     <= imem_rdata;
                            r_dec_pc <= r_pc;
                            if (w_trap) begin
                                r_state <= TRAP;
`ifdef IFU_ILLEGAL_TRAP_EN
                                r_illegal <= 1'b1;
`endif
                            end else begin
                                r_state     <= ISSUE;
                                r_dec_valid <= 1'b1;
                            end
                        end
                    end else if (redir_valid) begin
                        r_redir_tgt  <= w_redir_tgt;
                        r_redir_pend <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (redir_valid) begin
                        r_pc        <= w_redir_tgt;
                        r_dec_valid <= 1'b0;
                        r_state     <= FETCH;
                        r_imem_req  <= 1'b1;
                    end else if (dec_ready) begin
                        r_pc        <= w_pc_next;
                        r_dec_valid <= 1'b0;
                        if (run) begin
                            r_state    <= FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                TRAP: begin
                    r_imem_req  <= 1'b0;
                    r_dec_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign dec_valid = r_dec_valid;
    assign dec_pc    = r_dec_pc;
    assign instr     = r_ir;
    assign opcode    = r_ir[6:0];
    assign rd        = r_ir[11:7];
    assign funct3    = r_ir[14:12];
    assign rs1       = r_ir[19:15];
    assign rs2       = r_ir[24:20];
    assign funct7    = r_ir[31:25];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle fetch stage for the RV32 subset core (R-type ADD/SUB/AND/XOR/SLL, SW, LUI, ADDI/LI, LW).
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents it to decode with a valid/ready handshake.
- Drives the opcode/funct3/funct7/register fields consumed directly by the control unit and register file.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  fetch enable; when low, the FSM parks in IDLE after the current instruction is consumed.
- imem_req  out  1  memory request.
- imem_addr  out  XLEN  word address, equal to pc, low 2 bits always 0.
- imem_ack  in  1  response valid; imem_rdata is sampled in this cycle.
- imem_rdata  in  32  fetched instruction.
- redir_valid  in  1  PC redirect request, single-cycle pulse.
- redir_pc  in  XLEN  redirect target; bits [1:0] are forced to 0.
- dec_valid  out  1  IR holds an instruction for decode.
- dec_ready  in  1  decode accepts the instruction.
- dec_pc  out  XLEN  PC of the instruction held in IR.
- instr  out  32  IR contents.
- opcode  out  7  IR[6:0].
- rd  out  5  IR[11:7].
- funct3  out  3  IR[14:12].
- rs1  out  5  IR[19:15].
- rs2  out  5  IR[24:20].
- funct7  out  7  IR[31:25].
- illegal  out  1  sticky unsupported-opcode flag (see Optional Feature).

Behaviour:
- Reset (async, any state): state=IDLE; pc=RESET_PC; IR=32'h0000_0013 (ADDI x0,x0,0 NOP); dec_pc=RESET_PC; imem_req=0; dec_valid=0; illegal=0; redir_pend=0.
- Field outputs are pure slices of IR; they change only when IR is loaded.
- States:
  - IDLE: outputs quiet. If run=1, go to FETCH on the next edge.
  - FETCH: imem_req=1, imem_addr=pc.
    - req and addr stay stable until imem_ack.
    - imem_ack may assert in the first FETCH cycle or any later cycle.
    - On ack with redir_pend=0: IR<=imem_rdata, dec_pc<=pc, go to ISSUE.
    - On ack with redir_pend=1: discard rdata, pc<=latched target, clear redir_pend, stay in FETCH with a fresh request next cycle. imem_req drops for one cycle.
  - ISSUE: dec_valid=1, imem_req=0.
    - On dec_ready: pc<=pc+PC_STEP. Go to FETCH if run=1, else IDLE.
- Throughput: at most one instruction per 2 cycles. With zero-wait memory, ack is seen in the FETCH cycle and dec_valid rises the next cycle.
- Redirect rules:
  - In FETCH without ack: latch redir_pc into the pending target and set redir_pend. The memory request is never aborted.
  - In FETCH in the same cycle as ack: treated as pending. Data is discarded and the target is refetched.
  - In ISSUE: dec_valid deasserts next cycle, IR is retained but invalid, pc<=redir_pc, go to FETCH.
  - In ISSUE together with dec_ready: the current instruction counts as consumed; pc<=redir_pc, not pc+4.
  - In IDLE: pc<=redir_pc.
  - A second redirect while pending overwrites the target; the last one wins.
- PC arithmetic: modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- run deassert mid-FETCH: the outstanding request completes and the instruction is issued, then the FSM parks in IDLE.

Optional Feature:
- Macro: IFU_ILLEGAL_TRAP_EN.
- Defined: on ack (redir_pend=0), if opcode is not one of 0110011, 0100011, 0110111, 0010011, 0000011:
  - IR is loaded, illegal<=1, state goes to TRAP.
  - TRAP: dec_valid=0, imem_req=0, ignores run and redir. Exit only by reset.
- Undefined: no check; illegal is tied 0; every word is issued.

Decomposition:
- Shared include/package rv_defs holds:
  - opcode constants OP_R, OP_STORE, OP_LUI, OP_IMM, OP_LOAD;
  - the NOP encoding 32'h0000_0013;
  - the FSM state encoding (IDLE, FETCH, ISSUE, TRAP), also used by the bench.
- No sub-module is required. Field slicing stays inline; the PC register with its redirect mux lives in the same module.

Test Plan:
- Reset, run=1, zero-wait memory returning addr-derived words → imem_addr sequence 0,4,8; dec_valid every second cycle; dec_pc matches; fields of 32'h4020_81B3 give opcode=0110011, funct7=0100000, funct3=000, rd=3.
- Memory ack delayed 3 cycles, dec_ready held low 2 cycles → imem_addr stable for the whole request; IR/dec_valid stable until ready; no PC advance.
- Redirect to 32'h0000_0103 mid-FETCH → current rdata dropped, never issued; next request addr=32'h0000_0100.
- Redirect in the same cycle as dec_ready in ISSUE → next fetch addr = redirect target, not pc+4.
- pc=32'hFFFF_FFFC consumed → next imem_addr=0. Reset asserted mid-FETCH → imem_req=0 immediately (async), pc=RESET_PC.
- With IFU_ILLEGAL_TRAP_EN, fetch 32'h0000_0063 → illegal=1, dec_valid stays 0, no further imem_req. Without the macro, the same word issues with opcode=1100011.
